pipe_exec_core: RTL
===================

PIPE_EXEC_CORE -- requirements
Module: pipe_exec_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, ≥4); AW = log2(NREG).
REQ-003 SHALL have parameter DEPTH, default 3, post-issue stages (≥2); stage 1 = EX, stage DEPTH = WB.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports are clk and reset.
REQ-005 Ports, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  issue request.
- in_ready  out  1  issue accepted when in_valid & in_ready at the clock edge.
- in_op  in  3  operation code.
- in_rs, in_rt, in_rd  in  AW each  sources and destination.
- in_imm  in  XLEN  immediate.
- in_use_imm  in  1  B operand = in_imm instead of R[rt].
- in_we  in  1  write result to rd.
- flush  in  1  kill all in-flight work.
- wb_valid  out  1  retirement strobe.
- wb_rd  out  AW  retired destination.
- wb_data  out  XLEN  retired result.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  combinational R[dbg_addr].
- retire_cnt  out  32  count of retired instructions.

Function
REQ-006 Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SLL (A << B[AW'-1:0], AW' = log2(XLEN)), 111 MUL (low XLEN bits of product); all results wrap modulo 2^XLEN.
REQ-007 Register 0 SHALL always read 0; writes to it are discarded, and it never forwards or stalls.
REQ-008 On acceptance, operand A = R[rs], and B = in_imm if in_use_imm, else R[rt]; both are captured into stage 1 in the same edge.
REQ-009 Operand values SHALL be forwarded from the youngest valid in-flight stage k (1..DEPTH) with we=1 and rd equal to the source; otherwise the value SHALL come from the register file.
REQ-010 Non-MUL results SHALL be computed in stage 1 (combinationally) and be forwardable from stage 1 onward.
REQ-011 MUL results SHALL be registered and be forwardable from stage 2 onward.
REQ-012 Hazard: if the youngest match for a used source is a stage-1 MUL, in_ready SHALL be 0 for that cycle; a bubble enters stage 1 and the stall lasts exactly one cycle.
REQ-013 in_ready SHALL be 0 while flush=1 or reset=1; otherwise it SHALL be 1 except under REQ-012.
REQ-014 The pipeline SHALL advance every cycle (no backpressure from WB); stage k+1 takes stage k each edge, and an unaccepted cycle inserts a bubble (valid=0).
REQ-015 Instruction latency SHALL be DEPTH cycles. The instruction retires in the cycle it occupies stage DEPTH: wb_valid=1, wb_rd=rd (0 if we=0), wb_data=result, and the register write commits at the end of that cycle.
REQ-016 wb_valid SHALL also pulse for we=0 instructions; no register write occurs for them.
REQ-017 flush=1 SHALL clear the valid bit of every stage at the next edge, including stage DEPTH: its write is suppressed and wb_valid is 0 in the flush cycle. No issue is accepted in that cycle.
REQ-018 retire_cnt SHALL increment once per wb_valid and wrap from 2^32-1 to 0.
REQ-019 dbg_data SHALL reflect committed register-file contents only, never forwarded values.

Reset
REQ-020 While reset is high: all stage valid bits 0, all registers 0, retire_cnt 0, wb_valid 0, wb_rd 0, wb_data 0, in_ready 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight instructions with no register write. The first issue is accepted on the first edge after deassertion.

Verification
REQ-022 Independent ops ADD r1=r0+5, then ADD r2=r0+7 (in_use_imm) -> wb at cycles 3 and 4 with data 5 and 7; dbg r1=5, r2=7; retire_cnt=2.
REQ-023 Back-to-back dependency: r1=r0+5; r2=r1+r1; r3=r2-r1 -> no stall; wb_data 5, 10, 5 on consecutive cycles.
REQ-024 MUL hazard: r4=r0+3; r5=r4*r4; r6=r5+r0 -> in_ready=0 for exactly one cycle before r6 issues; r5=9, r6=9; one bubble cycle with wb_valid=0.
REQ-025 Flush: issue 3 writes to r7 (values 1, 2, 3), then assert flush the cycle after the third issue -> the oldest may retire if it is already at WB before the flush cycle, all others are discarded, and r7 holds only the retired value.
REQ-026 Edge cases: SLT 0x80000000 < 1 -> 1; SLL 1 by 31 -> 0x80000000; ADD 0xFFFFFFFF+1 -> 0; write to r0 -> dbg r0 stays 0.
REQ-027 Parameter sweep DEPTH=2,4 and XLEN=16: latency equals DEPTH, and every scenario above passes with XLEN-scaled values.

Source files
------------

// File: rtl/pipe_exec_core_if.sv
// rtl/pipe_exec_core_if.sv - issue, retire and debug bundle for pipe_exec_core
interface pipe_exec_core_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [AW-1:0]   in_rs;
    logic [AW-1:0]   in_rt;
    logic [AW-1:0]   in_rd;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic            in_we;
    logic            flush;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [31:0]     retire_cnt;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_we,
        output flush, dbg_addr,
        input  in_ready, wb_valid, wb_rd, wb_data, dbg_data, retire_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_we,
        input  flush, dbg_addr,
        output in_ready, wb_valid, wb_rd, wb_data, dbg_data, retire_cnt
    );
endinterface

// File: rtl/pipe_exec_core.sv
// rtl/pipe_exec_core.sv - in-order execute pipeline with forwarding, MUL stall and flush
// Stage 1 holds operands (ALU result is combinational there); stages 2..DEPTH hold results.
module pipe_exec_core #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 3
) (
    input logic             clk,
    input logic             reset,
    pipe_exec_core_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int SH = $clog2(XLEN);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [XLEN-1:0] r_rf [NREG];
    logic            r_valid [1:DEPTH];
    logic [AW-1:0]   r_rd [1:DEPTH];
    logic            r_we [1:DEPTH];
    logic [XLEN-1:0] r_res [2:DEPTH];
    logic [2:0]      r_op1;
    logic            r_mul1;
    logic [XLEN-1:0] r_a1;
    logic [XLEN-1:0] r_b1;
    logic [31:0]     r_retire_cnt;

    logic [XLEN-1:0] w_alu1;
    logic [XLEN-1:0] w_mul1;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic            w_haz_a;
    logic            w_haz_b;
    logic            w_ready;
    logic            w_accept;
    logic            w_retire;

    always_comb begin
        w_alu1 = '0;
        case (r_op1)
            OP_ADD:  w_alu1 = r_a1 + r_b1;
            OP_SUB:  w_alu1 = r_a1 - r_b1;
            OP_AND:  w_alu1 = r_a1 & r_b1;
            OP_OR:   w_alu1 = r_a1 | r_b1;
            OP_XOR:  w_alu1 = r_a1 ^ r_b1;
            OP_SLT:  w_alu1 = {{(XLEN-1){1'b0}}, ($signed(r_a1) < $signed(r_b1))};
            OP_SLL:  w_alu1 = r_a1 << r_b1[SH-1:0];
            default: w_alu1 = '0;
        endcase
    end

    assign w_mul1 = r_a1 * r_b1;

    // Older stages first so the youngest match wins; r0 never matches since r_we excludes rd=0.
    always_comb begin
        w_op_a  = r_rf[bus.in_rs];
        w_op_b  = bus.in_use_imm ? bus.in_imm : r_rf[bus.in_rt];
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (r_valid[k] && r_we[k] && (r_rd[k] == bus.in_rs))
                w_op_a = r_res[k];
            if (r_valid[k] && r_we[k] && !bus.in_use_imm && (r_rd[k] == bus.in_rt))
                w_op_b = r_res[k];
        end
        if (r_valid[1] && r_we[1] && (r_rd[1] == bus.in_rs)) begin
            if (r_mul1) w_haz_a = 1'b1;
            else        w_op_a  = w_alu1;
        end
        if (r_valid[1] && r_we[1] && !bus.in_use_imm && (r_rd[1] == bus.in_rt)) begin
            if (r_mul1) w_haz_b = 1'b1;
            else        w_op_b  = w_alu1;
        end
    end

    assign w_ready  = !reset && !bus.flush && !w_haz_a && !w_haz_b;
    assign w_accept = bus.in_valid && w_ready;
    assign w_retire = r_valid[DEPTH] && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_rd[k]    <= '0;
                r_we[k]    <= 1'b0;
            end
            for (int k = 2; k <= DEPTH; k++) r_res[k] <= '0;
            r_op1        <= '0;
            r_mul1       <= 1'b0;
            r_a1         <= '0;
            r_b1         <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_valid[1] <= w_accept;
            r_rd[1]    <= bus.in_rd;
            r_we[1]    <= bus.in_we && (bus.in_rd != '0);
            r_op1      <= bus.in_op;
            r_mul1     <= (bus.in_op == OP_MUL);
            r_a1       <= w_op_a;
            r_b1       <= w_op_b;

            r_valid[2] <= r_valid[1] && !bus.flush;
            r_rd[2]    <= r_rd[1];
            r_we[2]    <= r_we[1];
            r_res[2]   <= r_mul1 ? w_mul1 : w_alu1;
            for (int k = 3; k <= DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1] && !bus.flush;
                r_rd[k]    <= r_rd[k-1];
                r_we[k]    <= r_we[k-1];
                r_res[k]   <= r_res[k-1];
            end

            if (w_retire && r_we[DEPTH])
                r_rf[r_rd[DEPTH]] <= r_res[DEPTH];
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.wb_valid   = w_retire;
    assign bus.wb_rd      = (w_retire && r_we[DEPTH]) ? r_rd[DEPTH] : '0;
    assign bus.wb_data    = w_retire ? r_res[DEPTH] : '0;
    assign bus.dbg_data   = r_rf[bus.dbg_addr];
    assign bus.retire_cnt = r_retire_cnt;
endmodule
